// File: rtl/subpel_pkg.sv
// subpel_pkg: shared constants and FSM state encoding for the fractional-pel
// SAD controller (subpel_sad_ctrl) and its per-candidate row adder (sad6_sum).
package subpel_pkg;

  localparam int         NUM_CAND   = 25;
  localparam logic [4:0] CENTER_IDX = 5'd12;
  localparam int         NUM_ROWS   = 8;
  localparam int         DIFF_W     = 48;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_SEARCH = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

endpackage

// File: rtl/sad6_sum.sv
// sad6_sum: combinational sum of the six 8-bit absolute differences of one
// candidate's datapath slice.
//   diff_i  in  48  six bytes, byte 0 in [7:0]
//   sum_o   out 11  zero-extended sum (max 6*255 = 1530)
module sad6_sum
  import subpel_pkg::*;
(
  input  logic [DIFF_W-1:0] diff_i,
  output logic [10:0]       sum_o
);

  // Adder tree over the six bytes; 11 bits cannot overflow.
  always_comb begin
    sum_o = 11'd0;
    for (int b = 0; b < 6; b++) begin
      sum_o = sum_o + {3'd0, diff_i[8*b +: 8]};
    end
  end

endmodule

// File: rtl/subpel_sad_ctrl.sv
// subpel_sad_ctrl: loads an 8-row reference block plus original rows through
// a valid/ready stream, feeds a 3-row sliding window to the 25-candidate
// absolute-difference datapath, accumulates per-candidate SAD over the six
// inner rows and scans the totals for the best fractional offset.
//   clk, rst                   clock, async active-high reset
//   start                      begin a search (IDLE only)
//   in_valid / in_ready        input beat handshake (ready only in LOAD)
//   in_cur / in_org            reference row k / original row k
//   cur_upper/middle/lower_pix window rows m-1, m, m+1 to datapath
//   org_pix                    original row m to datapath
//   diff_all                   25 x 48-bit datapath results
//   busy, done                 status; done is a one-cycle pulse
//   best_idx, best_sad         winning candidate and its SAD
module subpel_sad_ctrl
  import subpel_pkg::*;
#(
  parameter int ACC_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                in_cur,
  input  logic [63:0]                in_org,
  output logic [63:0]                cur_upper_pix,
  output logic [63:0]                cur_middle_pix,
  output logic [63:0]                cur_lower_pix,
  output logic [63:0]                org_pix,
  input  logic [NUM_CAND*DIFF_W-1:0] diff_all,
  output logic                       busy,
  output logic                       done,
  output logic [4:0]                 best_idx,
  output logic [ACC_W-1:0]           best_sad
);

  state_e           state_q;
  logic [2:0]       k_q;
  logic [4:0]       j_q;
  logic             win_vld_q;
  logic [63:0]      org_hold_q;
  logic [63:0]      upper_q, middle_q, lower_q, org_q;
  logic             in_ready_q, busy_q, done_q;
  logic [4:0]       best_idx_q;
  logic [ACC_W-1:0] best_sad_q;

  logic [10:0]      row_sum_s [NUM_CAND];
  logic [ACC_W-1:0] acc_q     [NUM_CAND];
  logic [ACC_W-1:0] acc_d     [NUM_CAND];

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_sum
    sad6_sum u_sum (
      .diff_i (diff_all[gi*DIFF_W +: DIFF_W]),
      .sum_o  (row_sum_s[gi])
    );
  end

  // Next accumulator values: add the current row sum while the window is valid.
  always_comb begin
    for (int c = 0; c < NUM_CAND; c++) begin
      if (win_vld_q) begin
        acc_d[c] = acc_q[c] + ACC_W'(row_sum_s[c]);
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
  end

  // Accumulator bank, cleared when a search is started.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NUM_CAND; c++) acc_q[c] <= '0;
    end else if (state_q == ST_IDLE && start) begin
      for (int c = 0; c < NUM_CAND; c++) acc_q[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_CAND; c++) acc_q[c] <= acc_d[c];
    end
  end

  // Control FSM with window shifting, best-candidate scan and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      k_q        <= 3'd0;
      j_q        <= 5'd0;
      win_vld_q  <= 1'b0;
      org_hold_q <= 64'd0;
      upper_q    <= 64'd0;
      middle_q   <= 64'd0;
      lower_q    <= 64'd0;
      org_q      <= 64'd0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      best_idx_q <= 5'd0;
      best_sad_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            state_q    <= ST_LOAD;
            k_q        <= 3'd0;
            win_vld_q  <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            best_idx_q <= 5'd0;
            best_sad_q <= '0;
          end
        end
        ST_LOAD: begin
          if (in_valid && in_ready_q) begin
            upper_q    <= middle_q;
            middle_q   <= lower_q;
            lower_q    <= in_cur;
            org_q      <= org_hold_q;
            org_hold_q <= in_org;
            // Window becomes complete (rows k-2..k) from beat 2 on.
            win_vld_q  <= (k_q >= 3'd2);
            k_q        <= k_q + 3'd1;
            if (k_q == 3'(NUM_ROWS - 1)) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end else begin
            // A gap must not repeat the previous row's accumulation.
            win_vld_q <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Final accumulation happens on this edge, so seed from acc_d.
          win_vld_q  <= 1'b0;
          state_q    <= ST_SEARCH;
          best_idx_q <= CENTER_IDX;
          best_sad_q <= acc_d[CENTER_IDX];
          j_q        <= 5'd0;
        end
        ST_SEARCH: begin
          // Strict compare keeps the center, then the lowest index, on ties.
          if (acc_q[j_q] < best_sad_q) begin
            best_idx_q <= j_q;
            best_sad_q <= acc_q[j_q];
          end
          if (j_q == 5'(NUM_CAND - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            j_q <= j_q + 5'd1;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
          done_q     <= 1'b0;
          win_vld_q  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign best_idx       = best_idx_q;
  assign best_sad       = best_sad_q;
  assign cur_upper_pix  = upper_q;
  assign cur_middle_pix = middle_q;
  assign cur_lower_pix  = lower_q;
  assign org_pix        = org_q;

endmodule

// File: tb/tb_subpel_sad_ctrl.sv
// Directed bench for subpel_sad_ctrl: diff_all is driven directly with
// constant patterns, so each candidate's SAD is 6 x (sum of its six bytes).
module tb_subpel_sad_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [63:0]   in_cur = 64'd0;
  logic [63:0]   in_org = 64'd0;
  logic [63:0]   cur_upper_pix, cur_middle_pix, cur_lower_pix, org_pix;
  logic [1199:0] diff_all = '0;
  logic          busy, done;
  logic [4:0]    best_idx;
  logic [13:0]   best_sad;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  subpel_sad_ctrl #(.ACC_W(14)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_cur         (in_cur),
    .in_org         (in_org),
    .cur_upper_pix  (cur_upper_pix),
    .cur_middle_pix (cur_middle_pix),
    .cur_lower_pix  (cur_lower_pix),
    .org_pix        (org_pix),
    .diff_all       (diff_all),
    .busy           (busy),
    .done           (done),
    .best_idx       (best_idx),
    .best_sad       (best_sad)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [63:0] row_val(input int k);
    logic [7:0] b;
    b = 8'h10 + 8'(k);
    return {8{b}};
  endfunction

  function automatic logic [63:0] org_val(input int k);
    logic [7:0] b;
    b = 8'h40 + 8'(k);
    return {8{b}};
  endfunction

  // All candidates' bytes = base, except candidates ca and cb (if >= 0).
  task automatic set_diff(input logic [7:0] base, input int ca, input logic [7:0] va,
                          input int cb, input logic [7:0] vb);
    for (int c = 0; c < 25; c++) begin
      for (int b = 0; b < 6; b++) begin
        if (c == ca) diff_all[48*c + 8*b +: 8] = va;
        else if (c == cb) diff_all[48*c + 8*b +: 8] = vb;
        else diff_all[48*c + 8*b +: 8] = base;
      end
    end
  endtask

  task automatic load_beats(input logic gap, input int nbeats, output int t_cyc);
    t_cyc = 0;
    for (int k = 0; k < nbeats; k++) begin
      if (gap && k > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_cur   = row_val(k);
      in_org   = org_val(k);
      t_cyc    = cyc;
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic run_search(input string tag, input logic gap,
                            input logic [4:0] exp_idx, input logic [13:0] exp_sad);
    int s_cyc, t_cyc;
    s_cyc = cyc;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
    chk({tag, "_busy_load"}, {63'd0, busy}, 64'd1);
    load_beats(gap, 8, t_cyc);
    chk({tag, "_win_upper"}, cur_upper_pix, row_val(5));
    chk({tag, "_win_middle"}, cur_middle_pix, row_val(6));
    chk({tag, "_win_lower"}, cur_lower_pix, row_val(7));
    chk({tag, "_win_org"}, org_pix, org_val(6));
    chk({tag, "_in_ready_drain"}, {63'd0, in_ready}, 64'd0);
    while (!done && (cyc - t_cyc) < 60) tick();
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_lat_T"}, 64'(cyc - t_cyc), 64'd27);
    if (!gap) chk({tag, "_lat_S"}, 64'(cyc - s_cyc), 64'd35);
    chk({tag, "_best_idx"}, {59'd0, best_idx}, {59'd0, exp_idx});
    chk({tag, "_best_sad"}, {50'd0, best_sad}, {50'd0, exp_sad});
    tick();
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_busy_idle"}, {63'd0, busy}, 64'd0);
    chk({tag, "_idx_hold"}, {59'd0, best_idx}, {59'd0, exp_idx});
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_upper"}, cur_upper_pix, 64'd0);
    chk({tag, "_middle"}, cur_middle_pix, 64'd0);
    chk({tag, "_lower"}, cur_lower_pix, 64'd0);
    chk({tag, "_org"}, org_pix, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, done}, 64'd0);
    chk({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    chk({tag, "_best_idx"}, {59'd0, best_idx}, 64'd0);
    chk({tag, "_best_sad"}, {50'd0, best_sad}, 64'd0);
  endtask

  initial begin
    int t_dummy;
    #2;
    chk_reset_state("rst0");
    tick();
    rst = 1'b0;
    tick();
    chk_reset_state("idle0");

    // Candidate 3 bytes=1 -> 36; others bytes=2 -> 72.
    set_diff(8'd2, 3, 8'd1, -1, 8'd0);
    run_search("cand3", 1'b0, 5'd3, 14'd36);

    // All equal -> center wins the tie.
    set_diff(8'd5, -1, 8'd0, -1, 8'd0);
    run_search("tie_center", 1'b0, 5'd12, 14'd180);

    // Two zero candidates -> lowest index wins.
    set_diff(8'd9, 5, 8'd0, 7, 8'd0);
    run_search("tie_low", 1'b0, 5'd5, 14'd0);

    // Full-scale bytes -> 9180 without wrap.
    set_diff(8'd255, -1, 8'd0, -1, 8'd0);
    run_search("max", 1'b0, 5'd12, 14'd9180);

    // Gapped input: a duplicated or skipped accumulation changes 36.
    set_diff(8'd2, 3, 8'd1, -1, 8'd0);
    run_search("gap", 1'b1, 5'd3, 14'd36);

    // Abort after beat 4 with an asynchronous reset.
    set_diff(8'd7, 20, 8'd3, -1, 8'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    load_beats(1'b0, 5, t_dummy);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state("abort");
    tick();
    rst = 1'b0;
    tick();
    // Candidate 20 bytes=3 -> 108; others bytes=7 -> 252.
    run_search("after_abort", 1'b0, 5'd20, 14'd108);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
